gesture_frame_sequencer: RTL
============================

# gesture_frame_sequencer

Frame-level controller for the sign-to-text pipeline (colour conversion → skin decision → palm identification → finger identification → sign identification). It gates the pixel stream into the pipeline, generates row/column coordinates, and waits out pipeline latency at each frame end. It runs a palm-height training phase that produces the `palm_height_test` reference and the testing switch. In run mode it filters per-frame `sign_value` results, reporting a sign only when it stays stable across several frames.

## Interface
Parameters:
- `IMG_W`, 160, pixels per row; 2..255.
- `IMG_H`, 120, rows per frame; 1..255.
- `PIPE_LAT`, 4, cycles from the last accepted pixel to a valid `palm_height`/`sign_value`; ≥1.
- `TRAIN_FRAMES`, 4, frames averaged in training; power of two, 1..16.
- `STABLE_FRAMES`, 3, consecutive identical frame results required to report; 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; leaves IDLE when high.
- `train_req`  in  1  sampled with `start`; forces a training phase.
- `stop`  in  1  pulse; latched; honoured at the next frame end.
- `pix_valid`  in  1  upstream pixel present.
- `pix_ready`  out  1  sequencer accepts a pixel this cycle.
- `pix_row`  out  8  row of the current/next pixel.
- `pix_col`  out  8  column of the current/next pixel.
- `frame_start`  out  1  accept of pixel (0,0).
- `frame_end`  out  1  accept of pixel (IMG_H-1, IMG_W-1).
- `palm_height`  in  8  per-frame palm height from palm identification.
- `sign_value`  in  4  per-frame sign; 4'hF means no sign.
- `palm_height_test`  out  8  trained reference height.
- `testing_switch`  out  1  0 while training, 1 otherwise.
- `sign_out`  out  4  last reported sign.
- `sign_valid`  out  1  one-cycle pulse with new `sign_out`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, TRAIN_CAP, TRAIN_DRAIN, RUN_CAP, RUN_DRAIN.
- Accept: `acc = pix_valid & pix_ready`. `pix_ready` is 1 only in TRAIN_CAP or RUN_CAP.
- Coordinates: on `acc`, column increments. At IMG_W-1 the column wraps to 0 and the row increments. The last pixel clears both counters and enters the matching DRAIN state.
- Counters reset to 0 on every entry to a CAP state from IDLE.
- IDLE, `start`=1: enter TRAIN_CAP if `train_req`=1 or the trained flag is 0; otherwise enter RUN_CAP.
- Entering TRAIN_CAP from IDLE clears the training accumulator (8+log2(TRAIN_FRAMES) bits) and the frame count.
- DRAIN: a down-counter loaded with PIPE_LAT-1; the state lasts exactly PIPE_LAT cycles. Inputs are sampled on the last drain cycle.
- TRAIN_DRAIN last cycle: add `palm_height` to the accumulator and increment the frame count.
  - When the count reaches TRAIN_FRAMES, `palm_height_test` takes the accumulator value shifted right by log2(TRAIN_FRAMES), truncated. The trained flag is set, and the next state is RUN_CAP.
  - Otherwise the next state is TRAIN_CAP.
- RUN_DRAIN last cycle, with sample s:
  - If s equals the candidate, the stability count increments, saturating at STABLE_FRAMES. Otherwise the candidate takes s and the count becomes 1.
  - A report fires when the count reaches STABLE_FRAMES on this sample, s≠4'hF, and s≠`sign_out`.
  - Next state: RUN_CAP.
- The candidate and count clear on entry to RUN_CAP from IDLE or TRAIN_DRAIN. `sign_out` is not cleared.
- `stop`: latched in any non-IDLE state. At the end of any DRAIN state (after sampling), a latched stop sends the machine to IDLE and clears the latch. If training is incomplete at that point, `palm_height_test` and the trained flag are unchanged.
- `testing_switch` is 0 in TRAIN_CAP/TRAIN_DRAIN and 1 in every other state.

## Timing
- Reset values of all outputs are 0, except `testing_switch`=1. Reset also clears the state (IDLE), counters, accumulator, trained flag, candidate and stop latch. Reset mid-frame abandons the frame immediately.
- `pix_row`, `pix_col` and `pix_ready` are decoded from registers (no combinational path from `pix_valid`).
- `frame_start` and `frame_end` are combinational on `acc`, in the same cycle as the pixel.
- Per-frame cost is IMG_W·IMG_H accepted pixels plus PIPE_LAT drain cycles. `pix_ready`=0 throughout drain.
- `sign_valid`/`sign_out` update on the clock edge ending the last RUN_DRAIN cycle. `sign_valid` is high for exactly one cycle.
- `palm_height_test` updates on the same edge as the last TRAIN_DRAIN cycle.
- Simultaneous `stop` and last drain cycle: the stop is honoured at this frame end.
- `start` held high in IDLE restarts on the next cycle.

## Structure
- Shared package `sign_pkg`: state enum, `SIGN_NONE` = 4'hF, 8-bit coordinate/height widths. Used by the sign identification stage as well.
- One sub-module, `sign_stability_filter`: candidate, count, compare and report logic, enabled by a one-cycle sample strobe.
- The FSM, coordinate counters, drain counter and training accumulator live in the top module.

## Test plan
All scenarios use IMG_W=4, IMG_H=2, PIPE_LAT=3, TRAIN_FRAMES=4, STABLE_FRAMES=3.
- Reset then `start`=1, `train_req`=0: TRAIN_CAP entered (untrained). 8 accepts give `frame_end` on (1,3), then `pix_ready`=0 for exactly 3 cycles.
- Training with heights 10, 11, 12, 14: `palm_height_test`=11, `testing_switch` 0→1, then RUN_CAP.
- Run frames with signs 5, 5, 5, 5, 7: one `sign_valid` pulse after the third frame with `sign_out`=5; none after the fourth or fifth.
- Run frames with signs F, F, F: no `sign_valid`. Frames 2, 3, 2, 2, 2: a single report of 2 after the last frame.
- `pix_valid` toggling 1010…: coordinates advance only on accepts. `frame_start` occurs exactly once, at (0,0).
- `stop` pulse mid-frame: the frame completes and drains, then IDLE and `busy`=0. Async `rst` mid-frame: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/sign_pkg.sv
// Shared types and widths for the sign-to-text pipeline: sequencer state,
// coordinate/height/sign widths and the "no sign" code.
package sign_pkg;

  localparam int COORD_W  = 8;
  localparam int HEIGHT_W = 8;
  localparam int SIGN_W   = 4;

  localparam logic [SIGN_W-1:0] SIGN_NONE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAIN_CAP,
    ST_TRAIN_DRAIN,
    ST_RUN_CAP,
    ST_RUN_DRAIN
  } seq_state_t;

  function automatic logic is_cap(input seq_state_t s);
    return (s == ST_TRAIN_CAP) || (s == ST_RUN_CAP);
  endfunction

  function automatic logic is_drain(input seq_state_t s);
    return (s == ST_TRAIN_DRAIN) || (s == ST_RUN_DRAIN);
  endfunction

endpackage

// File: rtl/gesture_frame_sequencer_if.sv
// Pixel-stream handshake between the upstream source and the frame sequencer,
// including the coordinates and frame markers handed to the pipeline.
interface gesture_frame_sequencer_if;
  import sign_pkg::*;

  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_row;
  logic [COORD_W-1:0] pix_col;
  logic               frame_start;
  logic               frame_end;

  modport master (
    input  pix_valid,
    output pix_ready, pix_row, pix_col, frame_start, frame_end
  );

  modport slave (
    output pix_valid,
    input  pix_ready, pix_row, pix_col, frame_start, frame_end
  );

endinterface

// File: rtl/sign_stability_filter.sv
// Debounces per-frame sign results: a sign is reported once it has been seen
// on STABLE_FRAMES consecutive samples, is not "no sign", and is new.
module sign_stability_filter
  import sign_pkg::*;
#(
  parameter int STABLE_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [SIGN_W-1:0] sample,
  output logic [SIGN_W-1:0] sign_out,
  output logic              sign_valid
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

  logic [SIGN_W-1:0] candidate;
  logic [3:0]        count;
  logic [3:0]        count_next;
  logic              report;

  always_comb begin
    count_next = 4'd1;
    if (sample == candidate) begin
      count_next = (count == STABLE_N) ? count : count + 4'd1;
    end
    report = sample_en && (count_next == STABLE_N) &&
             (sample != SIGN_NONE) && (sample != sign_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate  <= '0;
      count      <= '0;
      sign_out   <= '0;
      sign_valid <= 1'b0;
    end else begin
      sign_valid <= report;
      if (clear) begin
        candidate <= '0;
        count     <= '0;
      end else if (sample_en) begin
        candidate <= sample;
        count     <= count_next;
      end
      if (report) begin
        sign_out <= sample;
      end
    end
  end

endmodule

// File: rtl/gesture_frame_sequencer.sv
// Frame-level controller: gates pixels into the pipeline, tracks coordinates,
// waits out pipeline latency, trains the palm-height reference and filters signs.
module gesture_frame_sequencer
  import sign_pkg::*;
#(
  parameter int IMG_W         = 160,
  parameter int IMG_H         = 120,
  parameter int PIPE_LAT      = 4,
  parameter int TRAIN_FRAMES  = 4,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                train_req,
  input  logic                stop,
  gesture_frame_sequencer_if.master pix,
  input  logic [HEIGHT_W-1:0] palm_height,
  input  logic [SIGN_W-1:0]   sign_value,
  output logic [HEIGHT_W-1:0] palm_height_test,
  output logic                testing_switch,
  output logic [SIGN_W-1:0]   sign_out,
  output logic                sign_valid,
  output logic                busy
);

  localparam int TF_LOG  = $clog2(TRAIN_FRAMES);
  localparam int ACC_W   = HEIGHT_W + TF_LOG;
  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [COORD_W-1:0] LAST_ROW   = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_COL   = COORD_W'(IMG_W - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);
  localparam logic [4:0]         TF_N       = 5'(TRAIN_FRAMES);

  seq_state_t state, next;

  logic [COORD_W-1:0] row, col;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [ACC_W-1:0]   accum, accum_next;
  logic [4:0]         frame_cnt;
  logic               trained;
  logic               stop_latch;

  logic acc, last_pix, drain_last, stop_pend, train_done;
  logic sample_en, filt_clear;

  always_comb begin
    acc        = pix.pix_valid & is_cap(state);
    last_pix   = (row == LAST_ROW) && (col == LAST_COL);
    drain_last = is_drain(state) && (drain_cnt == '0);
    stop_pend  = stop_latch | stop;
    accum_next = accum + ACC_W'(palm_height);
    train_done = (frame_cnt + 5'd1) == TF_N;

    next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          next = (train_req || !trained) ? ST_TRAIN_CAP : ST_RUN_CAP;
        end
      end
      ST_TRAIN_CAP: begin
        if (acc && last_pix) next = ST_TRAIN_DRAIN;
      end
      ST_TRAIN_DRAIN: begin
        // The frame's height is still folded in when a stop ends training here.
        if (drain_last) begin
          if (stop_pend)       next = ST_IDLE;
          else if (train_done) next = ST_RUN_CAP;
          else                 next = ST_TRAIN_CAP;
        end
      end
      ST_RUN_CAP: begin
        if (acc && last_pix) next = ST_RUN_DRAIN;
      end
      ST_RUN_DRAIN: begin
        if (drain_last) next = stop_pend ? ST_IDLE : ST_RUN_CAP;
      end
      default: next = ST_IDLE;
    endcase

    sample_en  = (state == ST_RUN_DRAIN) && drain_last;
    filt_clear = (next == ST_RUN_CAP) &&
                 ((state == ST_IDLE) || (state == ST_TRAIN_DRAIN));

    pix.pix_ready   = is_cap(state);
    pix.pix_row     = row;
    pix.pix_col     = col;
    pix.frame_start = acc && (row == '0) && (col == '0);
    pix.frame_end   = acc && last_pix;
    testing_switch  = !((state == ST_TRAIN_CAP) || (state == ST_TRAIN_DRAIN));
    busy            = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      row              <= '0;
      col              <= '0;
      drain_cnt        <= '0;
      accum            <= '0;
      frame_cnt        <= '0;
      trained          <= 1'b0;
      palm_height_test <= '0;
      stop_latch       <= 1'b0;
    end else begin
      state <= next;

      if ((state == ST_IDLE) && start) begin
        row <= '0;
        col <= '0;
      end else if (acc) begin
        if (last_pix) begin
          row <= '0;
          col <= '0;
        end else if (col == LAST_COL) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (is_cap(state)) begin
        drain_cnt <= DRAIN_LOAD;
      end else if (is_drain(state) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      if ((state == ST_IDLE) && (next == ST_TRAIN_CAP)) begin
        accum     <= '0;
        frame_cnt <= '0;
      end else if ((state == ST_TRAIN_DRAIN) && drain_last) begin
        accum     <= accum_next;
        frame_cnt <= frame_cnt + 5'd1;
        if (train_done) begin
          palm_height_test <= HEIGHT_W'(accum_next >> TF_LOG);
          trained          <= 1'b1;
        end
      end

      if (state != ST_IDLE) begin
        if (drain_last && stop_pend) stop_latch <= 1'b0;
        else if (stop)               stop_latch <= 1'b1;
      end
    end
  end

  sign_stability_filter #(
    .STABLE_FRAMES(STABLE_FRAMES)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .clear     (filt_clear),
    .sample_en (sample_en),
    .sample    (sign_value),
    .sign_out  (sign_out),
    .sign_valid(sign_valid)
  );

endmodule
